tmp_decim: RTL and testbench
============================

# tmp_decim

Decimation stage directly downstream of the temperature-sensor switched-capacitor controller. Consumes the comparator decision stream (one bit per controller evaluation, qualified by a strobe) and counts ones over a fixed window of samples to form a temperature code. Presents each code on a valid/ready interface to the register bank / readout logic. Conversion of one window is pipelined with holding the previous result.

## Interface
- WINDOW_LOG2, 8: window length = 2**WINDOW_LOG2 counted samples.
- SETTLE, 4: samples discarded after each enable rise, range 0..15.
- CODE_W, WINDOW_LOG2+1: code width; holds 0..2**WINDOW_LOG2 inclusive.

- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- en  in  1  conversion enable; level.
- sample_stb  in  1  one-cycle strobe: cmp_bit valid this cycle.
- cmp_bit  in  1  comparator decision; 1 = counted as "one".
- out_ready  in  1  consumer accepts code this cycle.
- code  out  CODE_W  number of ones in last completed window.
- code_valid  out  1  code holds an unconsumed result.
- busy  out  1  state is SETTLE or ACCUM.
- overrun  out  1  sticky: a completed window was dropped.

## Operation
- Reset values: code=0, code_valid=0, busy=0, overrun=0, state=IDLE, all counters 0.
- States: IDLE, SETTLE, ACCUM.
- IDLE: en=1 -> SETTLE (if SETTLE=0 -> ACCUM directly); settle, sample, ones counters cleared. Strobes in IDLE ignored, including the cycle en rises.
- SETTLE: each strobe increments settle counter; on the SETTLE-th strobe -> ACCUM. cmp_bit ignored.
- ACCUM: each strobe increments sample counter and adds cmp_bit to ones counter. On the strobe that completes 2**WINDOW_LOG2 samples: window result = ones + cmp_bit; counters cleared; stay in ACCUM (back-to-back windows, no resettle).
- en=0 in SETTLE or ACCUM: abort, partial window discarded, -> IDLE next cycle. Pending code/code_valid untouched.
- Result load: if code_valid=0 or out_ready=1 in completion cycle, code <= result, code_valid <= 1. Otherwise result dropped, code unchanged, overrun <= 1.
- Handshake: transfer when code_valid & out_ready; code_valid clears next cycle unless a new result loads in the same cycle (then stays 1 with new code, no overrun).
- code stable while code_valid=1 and out_ready=0.
- overrun clears only on reset or on IDLE->SETTLE transition.
- Arithmetic: ones counter CODE_W bits, cannot overflow (max 2**WINDOW_LOG2); sample counter WINDOW_LOG2 bits, wraps to 0 on completion.

## Timing
- code/code_valid update on the clk edge ending the completing-strobe cycle: latency 1 cycle from final strobe.
- busy reflects registered state; rises 1 cycle after en rises, falls 1 cycle after en falls.
- Strobes may arrive every cycle; no minimum spacing.
- out_ready may be held high permanently; no combinational path from out_ready to any output.
- Asynchronous reset mid-window: all outputs to reset values immediately; no partial result emitted.

## Structure
- Shared package tmp_pkg: state enum (IDLE, SETTLE, ACCUM), default WINDOW_LOG2/SETTLE constants, used also by controller-side benches.
- One sub-module natural: tmp_ones_counter (sample counter + ones accumulator with clear, done pulse, result output); top holds FSM and output register/handshake.

## Test plan
- WINDOW_LOG2=3, SETTLE=2, en=1, 10 strobes all cmp_bit=1, out_ready=1 -> first 2 discarded, code=8, code_valid pulse 1 cycle after 10th strobe.
- Alternating cmp_bit 0/1, strobe every cycle, WINDOW_LOG2=8, SETTLE=4 -> code=128 after 260 strobes; next window back-to-back gives 128 again with no gap.
- out_ready=0 over two completed windows (all ones then all zeros) -> code=8 held stable, second result dropped, overrun=1; en toggle 0->1 clears overrun.
- Completion strobe in same cycle as out_ready=1 on pending result -> new code loads, code_valid stays 1, overrun stays 0.
- en=0 after 5 of 8 window samples, then en=1 -> partial discarded, next code counts only new window after resettle.
- reset asserted mid-ACCUM with code_valid=1 -> code=0, code_valid=0, busy=0, overrun=0 immediately; strobes ignored until en seen in IDLE.

Source files
------------

// File: rtl/tmp_pkg.sv
// Shared types and defaults for the temperature-sensor decimation path.
package tmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ACCUM
    } tmp_state_e;

    localparam int TMP_WINDOW_LOG2 = 8;
    localparam int TMP_SETTLE      = 4;

endpackage

// File: rtl/tmp_decim_if.sv
// Result handshake between the decimator and the readout logic.
interface tmp_decim_if #(
    parameter int CODE_W = 9
);

    logic [CODE_W-1:0] code;
    logic              code_valid;
    logic              out_ready;

    modport master (
        output code,
        output code_valid,
        input  out_ready
    );

    modport slave (
        input  code,
        input  code_valid,
        output out_ready
    );

endinterface

// File: rtl/tmp_ones_counter.sv
// Sample counter and ones accumulator for one decimation window.
module tmp_ones_counter
    import tmp_pkg::*;
#(
    parameter int WINDOW_LOG2 = TMP_WINDOW_LOG2,
    parameter int CODE_W      = WINDOW_LOG2 + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              stb,
    input  logic              bit_in,
    output logic              done,
    output logic [CODE_W-1:0] result
);

    logic [WINDOW_LOG2-1:0] sample_cnt;
    logic [CODE_W-1:0]      ones;
    logic                   last;

    assign last   = &sample_cnt;
    assign done   = stb && last;
    // Result includes the completing sample, which is never registered.
    assign result = ones + CODE_W'(bit_in);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_cnt <= '0;
            ones       <= '0;
        end else if (clr) begin
            sample_cnt <= '0;
            ones       <= '0;
        end else if (stb) begin
            if (last) begin
                sample_cnt <= '0;
                ones       <= '0;
            end else begin
                sample_cnt <= sample_cnt + 1'b1;
                ones       <= ones + CODE_W'(bit_in);
            end
        end
    end

endmodule

// File: rtl/tmp_decim.sv
// Ones-count decimator: settle, accumulate windows, hold result for readout.
module tmp_decim
    import tmp_pkg::*;
#(
    parameter int WINDOW_LOG2 = TMP_WINDOW_LOG2,
    parameter int SETTLE      = TMP_SETTLE,
    parameter int CODE_W      = WINDOW_LOG2 + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        sample_stb,
    input  logic        cmp_bit,
    tmp_decim_if.master rsp,
    output logic        busy,
    output logic        overrun
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    tmp_state_e        state;
    logic [3:0]        settle_cnt;
    logic              cnt_clr;
    logic              acc_stb;
    logic              done;
    logic [CODE_W-1:0] result;

    // Counters only run while accumulating with enable still high.
    assign cnt_clr = (state != ST_ACCUM) || !en;
    assign acc_stb = sample_stb && !cnt_clr;

    tmp_ones_counter #(
        .WINDOW_LOG2 (WINDOW_LOG2),
        .CODE_W      (CODE_W)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr),
        .stb    (acc_stb),
        .bit_in (cmp_bit),
        .done   (done),
        .result (result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            settle_cnt     <= '0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
            rsp.code       <= '0;
            rsp.code_valid <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (en) begin
                        settle_cnt <= '0;
                        overrun    <= 1'b0;
                        busy       <= 1'b1;
                        state      <= (SETTLE == 0) ? ST_ACCUM
                                                    : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!en) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (sample_stb) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            settle_cnt <= '0;
                            state      <= ST_ACCUM;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (!en) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // A consumed slot may be refilled in the same cycle.
            if (done) begin
                if (!rsp.code_valid || rsp.out_ready) begin
                    rsp.code       <= result;
                    rsp.code_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rsp.code_valid && rsp.out_ready) begin
                rsp.code_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tmp_decim.sv
// Directed bench for tmp_decim with a result scoreboard.
module tb_tmp_decim;

    logic clk = 1'b0;
    logic reset;
    logic en3, stb3, bit3, busy3, ovr3;
    logic en8, stb8, bit8, busy8, ovr8;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] q3[$];
    logic [31:0] q8[$];

    tmp_decim_if #(.CODE_W(4)) if3 ();
    tmp_decim_if #(.CODE_W(9)) if8 ();

    tmp_decim #(
        .WINDOW_LOG2 (3),
        .SETTLE      (2),
        .CODE_W      (4)
    ) d3 (
        .clk        (clk),
        .reset      (reset),
        .en         (en3),
        .sample_stb (stb3),
        .cmp_bit    (bit3),
        .rsp        (if3.master),
        .busy       (busy3),
        .overrun    (ovr3)
    );

    tmp_decim #(
        .WINDOW_LOG2 (8),
        .SETTLE      (4),
        .CODE_W      (9)
    ) d8 (
        .clk        (clk),
        .reset      (reset),
        .en         (en8),
        .sample_stb (stb8),
        .cmp_bit    (bit8),
        .rsp        (if8.master),
        .busy       (busy8),
        .overrun    (ovr8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, obs, exp);
        end
    endtask

    // Inputs change at posedge+1; returns at posedge+1 after one edge.
    task automatic cyc3(input logic s, input logic b);
        stb3 = s;
        bit3 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc8(input logic s, input logic b);
        stb8 = s;
        bit8 = b;
        @(posedge clk);
        #1;
    endtask

    // Transfers happen at the next posedge; inputs are stable here.
    always @(negedge clk) begin
        if (if3.code_valid && if3.out_ready) begin
            chk("sb3_pending", 32'(q3.size() != 0), 32'd1);
            if (q3.size() != 0)
                chk("sb3_code", 32'(if3.code), q3.pop_front());
        end
        if (if8.code_valid && if8.out_ready) begin
            chk("sb8_pending", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0)
                chk("sb8_code", 32'(if8.code), q8.pop_front());
        end
    end

    initial begin
        logic [7:0] p;
        reset = 1'b1;
        en3 = 0; stb3 = 0; bit3 = 0;
        en8 = 0; stb8 = 0; bit8 = 0;
        if3.out_ready = 1'b0;
        if8.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_code3", 32'(if3.code), 32'd0);
        chk("rst_valid3", 32'(if3.code_valid), 32'd0);
        chk("rst_busy3", 32'(busy3), 32'd0);
        chk("rst_ovr3", 32'(ovr3), 32'd0);
        chk("rst_code8", 32'(if8.code), 32'd0);
        chk("rst_valid8", 32'(if8.code_valid), 32'd0);

        // 10 all-ones strobes: 2 settle, 8 counted
        if3.out_ready = 1'b1;
        en3 = 1'b1;
        cyc3(0, 0);
        chk("t1_busy", 32'(busy3), 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 9) q3.push_back(32'd8);
            cyc3(1, 1);
            if (i == 8)
                chk("t1_pre", 32'(if3.code_valid), 32'd0);
        end
        chk("t1_valid", 32'(if3.code_valid), 32'd1);
        cyc3(0, 0);
        chk("t1_clear", 32'(if3.code_valid), 32'd0);

        // Stalled consumer across two windows
        if3.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) q3.push_back(32'd8);
            cyc3(1, 1);
        end
        chk("t3_valid", 32'(if3.code_valid), 32'd1);
        chk("t3_code", 32'(if3.code), 32'd8);
        for (int i = 0; i < 8; i++) cyc3(1, 0);
        chk("t3_ovr", 32'(ovr3), 32'd1);
        chk("t3_hold", 32'(if3.code), 32'd8);
        repeat (3) cyc3(0, 0);
        chk("t3_stable", 32'(if3.code), 32'd8);
        if3.out_ready = 1'b1;
        cyc3(0, 0);
        chk("t3_drain", 32'(if3.code_valid), 32'd0);
        chk("t3_ovr_kept", 32'(ovr3), 32'd1);
        en3 = 1'b0;
        cyc3(0, 0);
        chk("t3_idle", 32'(busy3), 32'd0);
        chk("t3_ovr_idle", 32'(ovr3), 32'd1);
        en3 = 1'b1;
        cyc3(0, 0);
        chk("t3_ovr_clr", 32'(ovr3), 32'd0);
        chk("t3_busy", 32'(busy3), 32'd1);

        // Completion coincides with transfer of pending code
        cyc3(1, 1);
        cyc3(1, 1);
        if3.out_ready = 1'b0;
        p = 8'b1011_0001;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) q3.push_back(32'd4);
            cyc3(1, p[i]);
        end
        chk("t4_pend", 32'(if3.code_valid), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                if3.out_ready = 1'b1;
                q3.push_back(32'd3);
            end
            cyc3(1, i < 3);
        end
        chk("t4_valid", 32'(if3.code_valid), 32'd1);
        chk("t4_code", 32'(if3.code), 32'd3);
        chk("t4_ovr", 32'(ovr3), 32'd0);
        cyc3(0, 0);
        chk("t4_clear", 32'(if3.code_valid), 32'd0);

        // Abort after 5 samples, resettle, fresh window
        for (int i = 0; i < 5; i++) cyc3(1, 1);
        en3 = 1'b0;
        cyc3(1, 1);
        chk("t5_idle", 32'(busy3), 32'd0);
        en3 = 1'b1;
        cyc3(1, 1);
        chk("t5_busy", 32'(busy3), 32'd1);
        cyc3(1, 1);
        cyc3(1, 1);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) q3.push_back(32'd2);
            cyc3(1, (i == 2) || (i == 5));
        end
        chk("t5_valid", 32'(if3.code_valid), 32'd1);
        cyc3(0, 0);

        // Async reset mid-window with pending code and overrun
        if3.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) cyc3(1, 1);
        for (int i = 0; i < 8; i++) cyc3(1, 0);
        for (int i = 0; i < 3; i++) cyc3(1, 1);
        chk("t6_pre_ovr", 32'(ovr3), 32'd1);
        chk("t6_pre_valid", 32'(if3.code_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_code", 32'(if3.code), 32'd0);
        chk("t6_valid", 32'(if3.code_valid), 32'd0);
        chk("t6_busy", 32'(busy3), 32'd0);
        chk("t6_ovr", 32'(ovr3), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        if3.out_ready = 1'b1;
        cyc3(1, 1);
        chk("t6_busy_up", 32'(busy3), 32'd1);
        cyc3(1, 1);
        cyc3(1, 1);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) q3.push_back(32'd1);
            cyc3(1, i == 7);
            if (i == 6)
                chk("t6_pre", 32'(if3.code_valid), 32'd0);
        end
        chk("t6_result", 32'(if3.code_valid), 32'd1);
        cyc3(0, 0);

        // Full-size window, strobe every cycle, back-to-back
        if8.out_ready = 1'b1;
        en8 = 1'b1;
        cyc8(0, 0);
        chk("t2_busy", 32'(busy8), 32'd1);
        for (int i = 0; i < 516; i++) begin
            if (i == 259 || i == 515) q8.push_back(32'd128);
            cyc8(1, i[0]);
            if (i == 258 || i == 514)
                chk("t2_pre", 32'(if8.code_valid), 32'd0);
            if (i == 259 || i == 515)
                chk("t2_valid", 32'(if8.code_valid), 32'd1);
            if (i == 260)
                chk("t2_gap", 32'(if8.code_valid), 32'd0);
        end
        en8 = 1'b0;
        cyc8(0, 0);
        chk("t2_idle", 32'(busy8), 32'd0);
        cyc8(0, 0);

        chk("q3_empty", 32'(q3.size()), 32'd0);
        chk("q8_empty", 32'(q8.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
